// File: rtl/ifns_pkg.sv
// Shared widths, IFNS codeword weights and arbiter state encoding.
package ifns_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW_W   = 11;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned W11 = 144;
  localparam int unsigned W10 = 55;
  localparam int unsigned W9  = 34;
  localparam int unsigned W8  = 21;
  localparam int unsigned W7  = 13;
  localparam int unsigned W6  = 8;
  localparam int unsigned W5  = 5;
  localparam int unsigned W4  = 3;
  localparam int unsigned W3  = 2;
  localparam int unsigned W2  = 1;
  localparam int unsigned W1  = 1;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

endpackage

// File: rtl/encoderIFNS_8di_core.sv
// Combinational 8-bit to 11-bit IFNS crosstalk-avoidance encoder.
module encoderIFNS_8di_core
  import ifns_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   code_c
);

  localparam logic [DATA_W-1:0] WT [CW_W] = '{
    8'(W1), 8'(W2), 8'(W3), 8'(W4), 8'(W5), 8'(W6),
    8'(W7), 8'(W8), 8'(W9), 8'(W10), 8'(W11)
  };

  // LOW[k] is the largest value the bits below d(k+1) can still represent.
  localparam logic [DATA_W-1:0] LOW [CW_W] = '{
    8'd0,
    8'(W1),
    8'(W1 + W2),
    8'(W1 + W2 + W3),
    8'(W1 + W2 + W3 + W4),
    8'(W1 + W2 + W3 + W4 + W5),
    8'(W1 + W2 + W3 + W4 + W5 + W6),
    8'(W1 + W2 + W3 + W4 + W5 + W6 + W7),
    8'(W1 + W2 + W3 + W4 + W5 + W6 + W7 + W8),
    8'(W1 + W2 + W3 + W4 + W5 + W6 + W7 + W8 + W9),
    8'(W1 + W2 + W3 + W4 + W5 + W6 + W7 + W8 + W9 + W10)
  };

  logic [DATA_W-1:0] rem;
  logic              prev;
  logic              b;

  // Greedy MSB-first; inside the overlap band the bit follows its upper neighbour.
  always_comb begin
    rem    = data;
    prev   = 1'b0;
    b      = 1'b0;
    code_c = '0;
    for (int k = int'(CW_W) - 1; k >= 0; k--) begin
      if (rem > LOW[k]) begin
        b = 1'b1;
      end else if (rem < WT[k]) begin
        b = 1'b0;
      end else begin
        b = prev;
      end
      code_c[k] = b;
      if (b) begin
        rem = rem - WT[k];
      end
      prev = b;
    end
  end

endmodule

// File: rtl/ifns_enc_arbiter.sv
// Round-robin burst arbiter sharing one IFNS encoder onto a registered TSV-bus port.
module ifns_enc_arbiter
  import ifns_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned TAGW     = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [CW_W-1:0]        bus_d,
  output logic                   bus_valid,
  output logic [TAGW-1:0]        bus_tag,
  output logic                   bus_last,
  input  logic                   bus_ready
);

  localparam logic [CNT_W-1:0] CAP      = CNT_W'(MAXBURST - 1);
  localparam logic [TAGW-1:0]  LAST_IDX = TAGW'(NREQ - 1);

  arb_state_e        state;
  logic [TAGW-1:0]   ptr;
  logic [TAGW-1:0]   owner;
  logic [CNT_W-1:0]  cnt;

  logic [TAGW-1:0]   winner;
  logic              any_valid;
  logic [TAGW-1:0]   sel;
  logic              can_load;
  logic              xfer;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [CW_W-1:0]   enc_code;
  int unsigned       idx;

  function automatic logic [TAGW-1:0] wrap_inc(input logic [TAGW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + TAGW'(1);
  endfunction

  // First valid requester at or after ptr; scanning downward lets the nearest one win.
  always_comb begin
    winner    = ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % NREQ;
      if (req_valid[idx]) begin
        winner    = TAGW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    can_load  = !bus_valid || bus_ready;
    sel       = (state == ARB_OWN) ? owner : winner;
    req_ready = '0;
    if (!rst && can_load) begin
      if (state == ARB_OWN) begin
        req_ready[owner] = 1'b1;
      end else if (any_valid) begin
        req_ready[winner] = 1'b1;
      end
    end
    xfer     = |(req_valid & req_ready);
    sel_last = req_last[sel];
    sel_data = req_data[32'(sel) * DATA_W +: DATA_W];
  end

  encoderIFNS_8di_core u_enc (
    .data   (sel_data),
    .code_c (enc_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      bus_d     <= '0;
      bus_valid <= 1'b0;
      bus_tag   <= '0;
      bus_last  <= 1'b0;
    end else begin
      // Output slot: load on transfer, otherwise drain while holding the wires.
      if (xfer) begin
        bus_d     <= enc_code;
        bus_tag   <= sel;
        bus_last  <= sel_last;
        bus_valid <= 1'b1;
      end else if (bus_ready) begin
        bus_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (xfer) begin
            if (sel_last) begin
              ptr <= wrap_inc(winner);
            end else begin
              state <= ARB_OWN;
              owner <= winner;
              cnt   <= CNT_W'(1);
            end
          end
        end
        ARB_OWN: begin
          if (xfer) begin
            if (sel_last || cnt == CAP) begin
              state <= ARB_IDLE;
              ptr   <= wrap_inc(owner);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifns_enc_arbiter.sv
// Randomized and directed bench for ifns_enc_arbiter against a reference model.
module tb_ifns_enc_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic              bus_ready;

  logic [NREQ-1:0]   rdy_a, rdy_c;
  logic [10:0]       bd_a, bd_c;
  logic              bv_a, bv_c;
  logic [1:0]        bt_a, bt_c;
  logic              bl_a, bl_c;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one set per instance (0: cap 16, 1: cap 4).
  bit         m_busy [2];
  int         m_owner[2];
  int         m_ptr  [2];
  int         m_beats[2];
  bit         m_v    [2];
  logic [10:0] m_d   [2];
  int         m_t    [2];
  bit         m_l    [2];
  int         maxb   [2];

  always #5 clk = ~clk;

  ifns_enc_arbiter #(.NREQ(NREQ), .MAXBURST(16)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy_a), .bus_d(bd_a), .bus_valid(bv_a),
    .bus_tag(bt_a), .bus_last(bl_a), .bus_ready(bus_ready)
  );

  ifns_enc_arbiter #(.NREQ(NREQ), .MAXBURST(4)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy_c), .bus_d(bd_c), .bus_valid(bv_c),
    .bus_tag(bt_c), .bus_last(bl_c), .bus_ready(bus_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wt(input int k);
    case (k)
      0, 1: return 1;
      2: return 2;
      3: return 3;
      4: return 5;
      5: return 8;
      6: return 13;
      7: return 21;
      8: return 34;
      9: return 55;
      default: return 144;
    endcase
  endfunction

  function automatic logic [10:0] ref_enc(input int v);
    logic [10:0] c = '0;
    int r = v;
    int below;
    bit up = 0;
    bit b;
    for (int k = 10; k >= 0; k--) begin
      below = 0;
      for (int j = 0; j < k; j++) below += wt(j);
      if (r > below) b = 1;
      else if (r < wt(k)) b = 0;
      else b = up;
      c[k] = b;
      if (b) r -= wt(k);
      up = b;
    end
    return c;
  endfunction

  function automatic int wsum(input logic [10:0] c);
    int s = 0;
    for (int k = 0; k < 11; k++) if (c[k]) s += wt(k);
    return s;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready(input int u);
    logic [NREQ-1:0] r = '0;
    int j;
    if (rst) return r;
    if (m_v[u] && !bus_ready) return r;
    if (m_busy[u]) begin
      r[m_owner[u]] = 1'b1;
      return r;
    end
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr[u] + k) % NREQ;
      if (req_valid[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock: check ready, advance the model, check the registered bus.
  task automatic step();
    logic [NREQ-1:0] er;
    int hit;
    string nm;
    #1;
    for (int u = 0; u < 2; u++) begin
      nm = (u == 0) ? "a" : "c";
      er = exp_ready(u);
      check({"ready_", nm}, (u == 0) ? rdy_a : rdy_c, er);
      if (rst) begin
        m_busy[u] = 0; m_owner[u] = 0; m_ptr[u] = 0; m_beats[u] = 0;
        m_v[u] = 0; m_d[u] = '0; m_t[u] = 0; m_l[u] = 0;
      end else begin
        hit = -1;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && er[i]) hit = i;
        if (hit >= 0) begin
          m_d[u] = ref_enc(int'(req_data[hit*8 +: 8]));
          m_t[u] = hit;
          m_l[u] = req_last[hit];
          m_v[u] = 1;
          if (!m_busy[u]) begin
            if (req_last[hit]) m_ptr[u] = (hit + 1) % NREQ;
            else begin
              m_busy[u] = 1; m_owner[u] = hit; m_beats[u] = 1;
            end
          end else if (req_last[hit] || m_beats[u] + 1 == maxb[u]) begin
            m_busy[u] = 0;
            m_ptr[u] = (m_owner[u] + 1) % NREQ;
          end else begin
            m_beats[u]++;
          end
        end else if (bus_ready) begin
          m_v[u] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      nm = (u == 0) ? "a" : "c";
      check({"bus_d_", nm},     (u == 0) ? bd_a : bd_c, m_d[u]);
      check({"bus_valid_", nm}, (u == 0) ? bv_a : bv_c, m_v[u]);
      check({"bus_tag_", nm},   (u == 0) ? bt_a : bt_c, m_t[u]);
      check({"bus_last_", nm},  (u == 0) ? bl_a : bl_c, m_l[u]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [10:0] hold;
    int tags_cap[12];
    maxb[0] = 16;
    maxb[1] = 4;
    tags_cap = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 0};

    // Reset held two cycles with every requester valid.
    rst = 1'b1; req_valid = '1; req_last = '1; bus_ready = 1'b1; req_data = $urandom;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    check("first_grant", bt_a, 0);

    // Single-requester encodes and full sweep.
    do_reset();
    req_valid = 4'b0001; req_last = '1; req_data = '0;
    req_data[7:0] = 8'd255; step(); check("enc255", bd_a, 11'h781);
    req_data[7:0] = 8'd144; step(); check("enc144", bd_a, 11'h400);
    req_data[7:0] = 8'd0;   step(); check("enc0",   bd_a, 11'h000);
    for (int v = 0; v < 256; v++) begin
      req_data[7:0] = 8'(v);
      step();
      check("wsum", wsum(bd_a), v);
    end

    // Fairness: all valid, single-beat packets.
    do_reset();
    req_valid = '1; req_last = '1;
    for (int k = 0; k < 8; k++) begin
      req_data = $urandom;
      step();
      check("fair_tag", bt_a, k % NREQ);
      check("fair_valid", bv_a, 1);
    end

    // Burst lock: requester 1 sends five beats while requester 2 waits.
    do_reset();
    req_last = 4'b0100;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'b0110 : 4'b0100;
      req_last[1] = (k == 4);
      req_data = $urandom;
      step();
      check("lock_tag", bt_a, (k < 5) ? 1 : 2);
    end

    // Burst cap of 4 on the second instance.
    do_reset();
    req_valid = 4'b1001; req_last = 4'b1000;
    for (int k = 0; k < 12; k++) begin
      req_data = $urandom;
      step();
      check("cap_tag", bt_c, tags_cap[k]);
    end

    // Backpressure mid-burst, then reset inside the burst.
    do_reset();
    req_valid = 4'b0001; req_last = '0;
    step();
    step();
    bus_ready = 1'b0;
    hold = bd_a;
    for (int k = 0; k < 3; k++) begin
      req_data = $urandom;
      #1 check("bp_ready", rdy_a, 0);
      step();
      check("bp_hold", bd_a, hold);
    end
    bus_ready = 1'b1;
    rst = 1'b1;
    step();
    check("rst_valid", bv_a, 0);
    rst = 1'b0;
    req_valid = 4'b0101; req_last = '1;
    step();
    check("resume_tag", bt_a, 0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      req_valid = 4'($urandom);
      req_data = $urandom;
      for (int i = 0; i < NREQ; i++) req_last[i] = ($urandom_range(0, 2) == 0);
      bus_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifns_enc_arbiter.md
# ifns_enc_arbiter

Round-robin scheduler that shares one 8-bit IFNS crosstalk-avoidance encoder core among `NREQ` byte-stream requesters and drives the resulting 11-bit codewords onto a single registered TSV-bus transmit port. It sits between the on-die byte producers and the bus line drivers. It supports packet bursts: a grant is held until `last` or until a burst-length cap is reached. When idle, the wires hold the last codeword, so no spurious transitions occur.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `MAXBURST`, 16, maximum beats per grant before forced rotation (2..256)
- `TAGW`, `$clog2(NREQ)`, width of the channel tag (derived; do not override)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester beat valid
- `req_data`  in  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
- `req_last`  in  NREQ  per-requester end-of-packet flag, qualified by `req_valid`
- `req_ready`  out  NREQ  per-requester accept strobe; at most one bit high
- `bus_d`  out  11  registered codeword d[11:1]
- `bus_valid`  out  1  codeword valid
- `bus_tag`  out  TAGW  index of the requester that sourced `bus_d`
- `bus_last`  out  1  registered `req_last` of the transferred beat
- `bus_ready`  in  1  downstream accept

## Operation
- Output slot:
  - `can_load = !bus_valid || bus_ready`.
  - A transfer from requester i occurs when `req_valid[i] && req_ready[i]`.
  - On transfer, `bus_d` loads `enc(req_data[i])`, `bus_tag` loads i, `bus_last` loads `req_last[i]`, and `bus_valid` is set to 1.
  - If `bus_ready` is high with no transfer, `bus_valid` clears to 0 while `bus_d`, `bus_tag` and `bus_last` hold their values.
- Encoding:
  - The encoding is greedy with weights 144, 55, 34, 21, 13, 8, 5, 3, 2, 1, 1 on d11..d1.
  - Each bit uses the IFNS ambiguity rule: when the remainder lies in the overlap band, the bit copies the next-higher bit.
  - Arithmetic is unsigned 8-bit, and the sum of the weighted codeword bits always equals the input.
- State machine, IDLE / OWN:
  - Registers: `ptr` (TAGW bits), `owner` (TAGW bits), `cnt` (8 bits).
  - **IDLE:** if `can_load` and any `req_valid` is high, the winner is the first valid index searching from `ptr` upward, modulo NREQ. Only the winner's `req_ready` is high, in the same cycle (combinational).
    - On transfer with `req_last=1`: stay in IDLE, `ptr <= winner+1 mod NREQ`.
    - On transfer with `req_last=0`: go to OWN, `owner <= winner`, `cnt <= 1`.
  - **OWN:** `req_ready[owner] = can_load`; all other ready bits are 0.
    - A transfer with `req_last=1`, or with `cnt == MAXBURST-1`, returns to IDLE with `ptr <= owner+1`.
    - Any other transfer increments `cnt`.
    - If the owner drops `req_valid`, the grant is held and bubbles are allowed.
- Boundaries:
  - A forced rotation at the cap does not alter the data. The requester's remaining beats continue once it is re-granted.
  - With NREQ requesters all valid, each is granted exactly once per NREQ grants.
  - `ptr` wraps from NREQ-1 to 0.
- Reset (mid-operation included): state IDLE, `ptr=0`, `owner=0`, `cnt=0`, `bus_valid=0`, `bus_d=0`, `bus_tag=0`, `bus_last=0`, `req_ready=0`. Any beat in the output register is discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented on `bus_*` after edge N, with `bus_valid=1` in cycle N+1.
- Throughput is 1 beat/cycle when `bus_ready=1`, including back-to-back grants to different requesters. IDLE arbitration adds no bubble.
- `req_ready` depends combinationally on `req_valid`, state and `bus_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- `bus_d` changes only on a transfer.

## Structure
- Package `ifns_pkg` holds:
  - `DATA_W=8`, `CW_W=11`
  - the weight constants `W11..W1` (144, 55, 34, 21, 13, 8, 5, 3, 2, 1, 1)
  - the state enum `{ARB_IDLE, ARB_OWN}`
- Sub-module: the existing `encoderIFNS_8di_core`, instantiated once and fed by the granted requester's byte through an NREQ:1 mux. The encode path is combinational before the output register.

## Test plan
- Reset: hold `rst` for 2 cycles with all `req_valid=1` -> all outputs 0 and `req_ready=0` during reset. First grant goes to requester 0 in the cycle after `rst` falls.
- Encode check: single requester sends 255 -> `bus_d=11'h781`. Sends 144 -> `11'h400`. Sends 0 -> `11'h000`. Full sweep 0..255 -> weighted sum equals input.
- Fairness: NREQ=4, all valid, `req_last=1` every beat, `bus_ready=1` -> `bus_tag` sequence 0,1,2,3,0,... with no bubbles.
- Burst lock: req1 sends 5 beats with last on beat 5 while req2 is valid throughout -> `bus_tag=1` for 5 cycles, then 2.
- Cap: MAXBURST=4, req0 streams 10 beats without last while req3 is valid -> tags 0,0,0,0,3,0,0,0,0,3,0,0.
- Backpressure and reset: `bus_ready=0` for 3 cycles mid-burst -> `bus_d` stable and `req_ready` all 0. Assert `rst` inside OWN -> IDLE, `bus_valid=0` next cycle, and the stream resumes from `ptr=0`.
